univ_shift_reg: RTL and testbench

Parametrised universal shift register. It is the successor to the fixed serial-in/serial-out shifter. It adds:
- bidirectional shift and rotate;
- parallel load and clear;
- a clock enable;
- full parallel and dual-end serial visibility;
- a shift counter that flags each completed N-bit frame.

It sits in the serialisation path between byte-wide datapaths and bit-serial links, and also serves as a general N-stage delay line.

---
 rtl/univ_shift_reg.sv | 111 +++++++++++
 tb/tb_univ_shift_reg.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : N-bit universal shift register (shift/rotate/load/clear) with a
//            shift counter that pulses frame_o on each completed N-bit frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             serial_l_i,
    input  logic             serial_r_i,
    input  logic [N-1:0]     parallel_i,
    output logic [N-1:0]     parallel_o,
    output logic             serial_l_o,
    output logic             serial_r_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             frame_o
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [N-1:0]     data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             frame_q, frame_d;
    logic             counting;

    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        frame_d  = 1'b0;
        counting = 1'b0;

        if (en_i) begin
            case (mode_i)
                MODE_HOLD: ;
                MODE_SHL: begin
                    data_d   = {data_q[N-2:0], serial_r_i};
                    counting = 1'b1;
                end
                MODE_SHR: begin
                    data_d   = {serial_l_i, data_q[N-1:1]};
                    counting = 1'b1;
                end
                MODE_ROL: begin
                    data_d   = {data_q[N-2:0], data_q[N-1]};
                    counting = 1'b1;
                end
                MODE_ROR: begin
                    data_d   = {data_q[0], data_q[N-1:1]};
                    counting = 1'b1;
                end
                MODE_LOAD: begin
                    data_d = parallel_i;
                    cnt_d  = '0;
                end
                MODE_CLEAR: begin
                    data_d = '0;
                    cnt_d  = '0;
                end
                default: ;  // reserved encoding behaves as HOLD
            endcase

            // Frame boundary: the N-th counting op wraps the counter and pulses.
            if (counting) begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d   = '0;
                    frame_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign parallel_o = data_q;
    assign serial_l_o = data_q[N-1];
    assign serial_r_o = data_q[0];
    assign cnt_o      = cnt_q;
    assign frame_o    = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Scoreboard-driven self-checking bench for univ_shift_reg (N=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

    localparam int N     = 8;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_ROL   = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_RSVD  = 3'b111;

    logic             clk_i;
    logic             rst_ni;
    logic             en_i;
    logic [2:0]       mode_i;
    logic             serial_l_i;
    logic             serial_r_i;
    logic [N-1:0]     parallel_i;
    logic [N-1:0]     parallel_o;
    logic             serial_l_o;
    logic             serial_r_o;
    logic [CNT_W-1:0] cnt_o;
    logic             frame_o;

    typedef struct {
        logic [N-1:0]     par;
        logic [CNT_W-1:0] cnt;
        logic             frame;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    univ_shift_reg #(.N(N)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .serial_l_i (serial_l_i),
        .serial_r_i (serial_r_i),
        .parallel_i (parallel_i),
        .parallel_o (parallel_o),
        .serial_l_o (serial_l_o),
        .serial_r_o (serial_r_o),
        .cnt_o      (cnt_o),
        .frame_o    (frame_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs, clock it, then settle #1 past the edge.
    task automatic step(input logic rst, input logic en, input logic [2:0] mode,
                        input logic sl, input logic sr, input logic [N-1:0] par);
        rst_ni     = rst;
        en_i       = en;
        mode_i     = mode;
        serial_l_i = sl;
        serial_r_i = sr;
        parallel_i = par;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{par: 8'h00, cnt: '0, frame: 1'b0});
            if (i < 2) step(1'b0, 1'b1, M_LOAD, 1'b0, 1'b0, 8'hFF);
            else       step(1'b1, 1'b1, M_HOLD, 1'b0, 1'b0, 8'hFF);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame ||
                serial_l_o !== 1'b0 || serial_r_o !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d] got par=%h cnt=%0d frame=%b sl=%b sr=%b want par=%h cnt=%0d frame=%b sl=0 sr=0",
                         i, parallel_o, cnt_o, frame_o, serial_l_o, serial_r_o, e.par, e.cnt, e.frame);
            end
        end
    endtask

    task automatic test_shl;
        logic [N-1:0] seq [8];
        logic         msb [8];
        seq = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
        msb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        sbq.push_back('{par: 8'hA5, cnt: '0, frame: 1'b0});
        step(1'b1, 1'b1, M_LOAD, 1'b0, 1'b0, 8'hA5);
        e = sbq.pop_front();
        checks++;
        if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
            errors++;
            $display("FAIL shl_load got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                     parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (serial_l_o !== msb[i]) begin
                errors++;
                $display("FAIL shl_serial_l[%0d] got %b want %b", i, serial_l_o, msb[i]);
            end
            sbq.push_back('{par: seq[i], cnt: CNT_W'((i + 1) % N), frame: (i == 7)});
            step(1'b1, 1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL shl[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
        sbq.push_back('{par: 8'h00, cnt: '0, frame: 1'b0});
        step(1'b1, 1'b1, M_HOLD, 1'b0, 1'b0, 8'h00);
        e = sbq.pop_front();
        checks++;
        if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
            errors++;
            $display("FAIL shl_after_frame got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                     parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
        end
    endtask

    task automatic test_rotate;
        logic [2:0]   modes [4];
        logic [N-1:0] pars  [4];
        modes = '{M_LOAD, M_ROR, M_ROL, M_ROL};
        pars  = '{8'h81, 8'hC0, 8'h81, 8'h03};
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{par: pars[i], cnt: CNT_W'(i), frame: 1'b0});
            step(1'b1, 1'b1, modes[i], 1'b0, 1'b0, 8'h81);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL rotate[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
    endtask

    task automatic test_shr_stream;
        logic         pat [8];
        logic [N-1:0] m;
        int           pulses;
        pat    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        m      = '0;
        pulses = 0;
        sbq.push_back('{par: 8'h00, cnt: '0, frame: 1'b0});
        step(1'b1, 1'b1, M_CLEAR, 1'b0, 1'b0, 8'hFF);
        e = sbq.pop_front();
        checks++;
        if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
            errors++;
            $display("FAIL shr_clear got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                     parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
        end
        for (int i = 0; i < 8; i++) begin
            m = {pat[i], m[N-1:1]};
            sbq.push_back('{par: m, cnt: CNT_W'((i + 1) % N), frame: (i == 7)});
            step(1'b1, 1'b1, M_SHR, pat[i], 1'b0, 8'h00);
            e = sbq.pop_front();
            if (frame_o === 1'b1) pulses++;
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame ||
                serial_r_o !== e.par[0]) begin
                errors++;
                $display("FAIL shr[%0d] got par=%h cnt=%0d frame=%b sr=%b want par=%h cnt=%0d frame=%b sr=%b",
                         i, parallel_o, cnt_o, frame_o, serial_r_o, e.par, e.cnt, e.frame, e.par[0]);
            end
        end
        checks++;
        if (parallel_o !== 8'h53 || pulses != 1) begin
            errors++;
            $display("FAIL shr_final got par=%h pulses=%0d want par=53 pulses=1", parallel_o, pulses);
        end
    endtask

    task automatic test_enable_abort;
        logic [N-1:0] m;
        int           pulses;
        m      = 8'h53;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            m = {m[N-2:0], 1'b1};
            sbq.push_back('{par: m, cnt: CNT_W'(i + 1), frame: 1'b0});
            step(1'b1, 1'b1, M_SHL, 1'b0, 1'b1, 8'h00);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL en_shl[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{par: m, cnt: CNT_W'(5), frame: 1'b0});
            step(1'b1, 1'b0, (i == 0) ? M_LOAD : M_SHL, 1'b1, 1'b1, 8'hEE);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL en_hold[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
        m = 8'h0F;
        sbq.push_back('{par: m, cnt: '0, frame: 1'b0});
        step(1'b1, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h0F);
        e = sbq.pop_front();
        checks++;
        if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
            errors++;
            $display("FAIL abort_load got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                     parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
        end
        for (int i = 0; i < 8; i++) begin
            m = {m[N-2:0], 1'b0};
            sbq.push_back('{par: m, cnt: CNT_W'((i + 1) % N), frame: (i == 7)});
            step(1'b1, 1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
            e = sbq.pop_front();
            if (frame_o === 1'b1) pulses++;
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL abort_shl[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL abort_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_and_reserved;
        logic [N-1:0] seq [4];
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F};
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{par: seq[i], cnt: CNT_W'(i + 1), frame: 1'b0});
            step(1'b1, 1'b1, M_SHL, 1'b0, 1'b1, 8'h00);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL mid_shl[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
        sbq.push_back('{par: 8'h00, cnt: '0, frame: 1'b0});
        step(1'b0, 1'b1, M_SHL, 1'b0, 1'b1, 8'h00);
        e = sbq.pop_front();
        checks++;
        if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
            errors++;
            $display("FAIL mid_reset got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                     parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
        end
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{par: 8'h00, cnt: '0, frame: 1'b0});
            step(1'b1, 1'b1, M_RSVD, 1'b1, 1'b1, 8'hFF);
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL rsvd[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
        end
        // Reserved mode must also hold a non-zero value and a non-zero count.
        sbq.push_back('{par: 8'h3C, cnt: '0, frame: 1'b0});
        sbq.push_back('{par: 8'h78, cnt: CNT_W'(1), frame: 1'b0});
        sbq.push_back('{par: 8'h78, cnt: CNT_W'(1), frame: 1'b0});
        step(1'b1, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h3C);
        step(1'b1, 1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) step(1'b1, 1'b1, M_RSVD, 1'b1, 1'b1, 8'hFF);
            else void'(sbq.pop_front());
            if (i == 1) void'(sbq.pop_front());
            e = sbq.pop_front();
            checks++;
            if (parallel_o !== e.par || cnt_o !== e.cnt || frame_o !== e.frame) begin
                errors++;
                $display("FAIL rsvd_hold[%0d] got par=%h cnt=%0d frame=%b want par=%h cnt=%0d frame=%b",
                         i, parallel_o, cnt_o, frame_o, e.par, e.cnt, e.frame);
            end
            if (i == 0) sbq.push_front(e);
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        en_i       = 1'b1;
        mode_i     = M_LOAD;
        serial_l_i = 1'b0;
        serial_r_i = 1'b0;
        parallel_i = 8'hFF;
        #2;
        test_reset();
        test_shl();
        test_rotate();
        test_shr_stream();
        test_enable_abort();
        test_reset_mid_and_reserved();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
